udp_frame_checker: RTL

- Consumer-side checker for the Ethernet test-frame stream: pops bytes from the receive FIFO, parses fixed-length frames and checks them.
- Each frame is a 2-byte frame index (LSB first) followed by PAYLOAD_BYTES payload bytes alternating PAT_EVEN, PAT_ODD.
- Checks frame-index sequence and payload pattern over one burst of FRAMES_PER_BURST frames, then reports pass/fail and counters to the control/debug logic.

---
 rtl/udp_frame_checker.sv | 109 ++++++++++
 1 files changed

// File: rtl/udp_frame_checker.sv
// udp_frame_checker: pops test frames (16-bit LSB-first index + alternating pattern payload) from the rx FIFO,
// checks index sequence and payload over one burst, and reports pass/fail and counters.
// Optional macro FRAME_TIMEOUT_EN adds a mid-frame idle abort with a timeout flag.
module udp_frame_checker #(
  parameter int PAYLOAD_BYTES = 1280,
  parameter int FRAMES_PER_BURST = 480,
  parameter logic [7:0] PAT_EVEN = 8'h1f,
`ifdef FRAME_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 65535,
`endif
  parameter logic [7:0] PAT_ODD = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rfifo_empty,
  output logic        rfifo_rd_en,
  input  logic [7:0]  rfifo_rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] frame_cnt,
  output logic [15:0] byte_err_cnt,
  output logic [15:0] idx_err_cnt,
`ifdef FRAME_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic [15:0] last_idx
);
  typedef enum logic [2:0] {IDLE, IDX_LO, IDX_HI, PAYLOAD, DONE} state_t;
  state_t state, next_state;
  logic rd_vld, last_pay, last_byte, to_hit, tmo, byte_ok;
  logic [7:0] idx_lo;
  logic [15:0] exp_idx, offset, idx;
  assign idx = {rfifo_rd_data, idx_lo};
  assign last_pay = state == PAYLOAD && offset == 16'(PAYLOAD_BYTES - 1);
  // the byte arriving now closes the burst; holding off the pop here keeps the FIFO from losing a byte
  assign last_byte = rd_vld && last_pay && frame_cnt + 16'd1 == 16'(FRAMES_PER_BURST);
  assign byte_ok = rfifo_rd_data == (offset[0] ? PAT_ODD : PAT_EVEN);
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign pass = done && byte_err_cnt == 16'd0 && idx_err_cnt == 16'd0 && !tmo;
  assign rfifo_rd_en = busy && !rfifo_empty && !last_byte && !to_hit;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // frame parser: advance only on a consumed byte; start re-arms from anywhere
  always_comb begin
    next_state = state;
    if (start) next_state = IDX_LO;
    else if (last_byte || to_hit) next_state = DONE;
    else if (rd_vld && busy) next_state = state == IDX_LO ? IDX_HI : state == IDX_HI ? PAYLOAD : last_pay ? IDX_LO : state;
  end
  // read-valid pipeline, index/payload checks and saturating counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_vld <= 1'b0;
      idx_lo <= 8'd0;
      exp_idx <= 16'd0;
      offset <= 16'd0;
      frame_cnt <= 16'd0;
      byte_err_cnt <= 16'd0;
      idx_err_cnt <= 16'd0;
      last_idx <= 16'd0;
    end else begin
      rd_vld <= rfifo_rd_en;
      if (start) begin
        exp_idx <= 16'd0;
        offset <= 16'd0;
        frame_cnt <= 16'd0;
        byte_err_cnt <= 16'd0;
        idx_err_cnt <= 16'd0;
        last_idx <= 16'd0;
      end else if (rd_vld && busy) begin
        if (state == IDX_LO) idx_lo <= rfifo_rd_data;
        if (state == IDX_HI) begin
          last_idx <= idx;
          exp_idx <= idx + 16'd1;
          offset <= 16'd0;
          if (idx != exp_idx && idx_err_cnt != 16'hFFFF) idx_err_cnt <= idx_err_cnt + 16'd1;
        end
        if (state == PAYLOAD) begin
          offset <= offset + 16'd1;
          if (!byte_ok && byte_err_cnt != 16'hFFFF) byte_err_cnt <= byte_err_cnt + 16'd1;
          if (last_pay) frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
`ifdef FRAME_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic in_frame;
  assign in_frame = state == IDX_HI || state == PAYLOAD;
  assign to_hit = in_frame && !rd_vld && !start && idle_cnt == 16'(TIMEOUT_CYC - 1);
  assign tmo = timeout;
  // mid-frame idle counter; a stalled frame is abandoned without being counted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle_cnt <= 16'd0;
      timeout <= 1'b0;
    end else begin
      idle_cnt <= (start || rd_vld || !in_frame) ? 16'd0 : idle_cnt + 16'd1;
      timeout <= !start && (timeout || to_hit);
    end
`else
  assign to_hit = 1'b0;
  assign tmo = 1'b0;
`endif
endmodule
